// File: rtl/rebal_pkg.sv
// Shared types, FSM state encoding and 16-bit saturation for the portfolio rebalancer.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package rebal_pkg;

    localparam int DOLLARS_W = 24;

    typedef logic signed [15:0]          price_t;
    typedef logic signed [15:0]          weight_t;
    typedef logic signed [15:0]          qty_t;
    typedef logic signed [DOLLARS_W-1:0] dollars_t;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        EMIT,
        FIN
    } rebal_state_t;

    localparam qty_t QTY_MAX = 16'sh7fff;
    localparam qty_t QTY_MIN = 16'sh8000;

    function automatic qty_t sat16(input logic signed [31:0] v);
        if (v > 32'(QTY_MAX)) begin
            return QTY_MAX;
        end else if (v < 32'(QTY_MIN)) begin
            return QTY_MIN;
        end
        return qty_t'(v[15:0]);
    endfunction

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; the start cycle performs the first step.
// Latency: done pulses DIVIDEND_W cycles after the start cycle, quotient held until the next start.
// Backpressure: none; the caller must consume the quotient before restarting.
module serial_divider #(
    parameter int DIVIDEND_W = 24,
    parameter int DIVISOR_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic                  done
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    logic [DIVISOR_W-1:0]  rem_q, div_q, src_rem, src_div, nxt_rem;
    logic [DIVIDEND_W-1:0] quo_q, src_quo;
    logic [CNT_W-1:0]      cnt_q;
    logic [DIVISOR_W:0]    shifted, trial;

    // The partial remainder stays below the divisor, so it never needs the extra bit.
    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        src_div = start ? divisor : div_q;
        shifted = {src_rem, src_quo[DIVIDEND_W-1]};
        trial   = shifted - {1'b0, src_div};
        nxt_rem = trial[DIVISOR_W] ? shifted[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
            cnt_q <= '0;
            done  <= 1'b0;
        end else if (start || cnt_q != '0) begin
            rem_q <= nxt_rem;
            div_q <= src_div;
            quo_q <= {src_quo[DIVIDEND_W-2:0], ~trial[DIVISOR_W]};
            cnt_q <= start ? CNT_W'(DIVIDEND_W - 1) : cnt_q - CNT_W'(1);
            done  <= start ? (DIVIDEND_W == 1) : (cnt_q == CNT_W'(1));
        end else begin
            done <= 1'b0;
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/portfolio_rebalancer.sv
// Turns Q1.14 target weights, prices and capital into per-stock share orders; optional REBAL_DEADBAND_EN.
// Latency: DIV_BITS+2 cycles per stock without backpressure; done one cycle after the last handshake.
// Backpressure: order_valid/idx/qty hold in EMIT until order_ready; start is ignored while busy.
module portfolio_rebalancer
    import rebal_pkg::*;
#(
    parameter int N_STOCKS = 3,
    parameter int W_FRAC   = 14,
`ifdef REBAL_DEADBAND_EN
    parameter int DEADBAND = 2,
`endif
    parameter int DIV_BITS = DOLLARS_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [N_STOCKS-1:0][15:0]     weights,
    input  logic [N_STOCKS-1:0][15:0]     prices,
    input  logic [15:0]                   capital,
    output logic                          busy,
    output logic                          order_valid,
    input  logic                          order_ready,
    output logic [$clog2(N_STOCKS)-1:0]   order_idx,
    output logic [15:0]                   order_qty,
    output logic [N_STOCKS-1:0][15:0]     holdings,
    output logic                          done,
    output logic                          err
);

    localparam int IDX_W = $clog2(N_STOCKS);
    localparam logic signed [32:0] D_MAX = (33'sd1 <<< (DIV_BITS - 1)) - 33'sd1;
    localparam logic signed [32:0] D_MIN = -(33'sd1 <<< (DIV_BITS - 1));

    rebal_state_t                state_q, state_d;
    logic [IDX_W-1:0]            idx_q;
    logic [15:0]                 cap_q;
    logic [N_STOCKS-1:0][15:0]   w_q, p_q;
    qty_t                        target_q;
    logic                        neg_q;

    weight_t                     w_cur;
    price_t                      price_cur;
    qty_t                        hold_cur, qty;
    logic signed [32:0]          prod, prod_sh;
    logic signed [DIV_BITS-1:0]  dollars;
    logic [DIV_BITS-1:0]         dollars_mag, div_quo;
    logic signed [31:0]          quo_signed;
    logic                        div_start, div_done;
    logic                        fire, skip, last;

    always_comb begin
        w_cur     = w_q[idx_q];
        price_cur = p_q[idx_q];
        hold_cur  = holdings[idx_q];
        prod      = 33'($signed({1'b0, cap_q})) * 33'(w_cur);
        prod_sh   = prod >>> W_FRAC;
        if (prod_sh > D_MAX) begin
            dollars = D_MAX[DIV_BITS-1:0];
        end else if (prod_sh < D_MIN) begin
            dollars = D_MIN[DIV_BITS-1:0];
        end else begin
            dollars = prod_sh[DIV_BITS-1:0];
        end
        dollars_mag = dollars[DIV_BITS-1] ? -dollars : dollars;
        quo_signed  = neg_q ? -32'(div_quo) : 32'(div_quo);
        qty         = sat16(32'(target_q) - 32'(hold_cur));
        last        = (idx_q == IDX_W'(N_STOCKS - 1));
    end

    serial_divider #(
        .DIVIDEND_W (DIV_BITS),
        .DIVISOR_W  (16)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (dollars_mag),
        .divisor  (p_q[idx_q]),
        .quotient (div_quo),
        .done     (div_done)
    );

    always_comb begin
        state_d     = state_q;
        div_start   = 1'b0;
        order_valid = 1'b0;
        skip        = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = MUL;
            MUL: begin
                if (price_cur <= 16'sd0) begin
                    state_d = EMIT;
                end else begin
                    div_start = 1'b1;
                    state_d   = DIV;
                end
            end
            DIV: if (div_done) state_d = EMIT;
            EMIT: begin
`ifdef REBAL_DEADBAND_EN
                skip = ((qty < 0) ? -32'(qty) : 32'(qty)) < DEADBAND;
`endif
                order_valid = !skip;
                if (skip || order_ready) state_d = last ? FIN : MUL;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign fire      = order_valid && order_ready;
    assign busy      = (state_q == MUL) || (state_q == DIV) || (state_q == EMIT);
    assign done      = (state_q == FIN);
    assign order_idx = idx_q;
    assign order_qty = (state_q == EMIT) ? qty : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cap_q    <= '0;
            w_q      <= '0;
            p_q      <= '0;
            target_q <= '0;
            neg_q    <= 1'b0;
            holdings <= '0;
            err      <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cap_q <= capital;
                        w_q   <= weights;
                        p_q   <= prices;
                        idx_q <= '0;
                    end
                end
                MUL: begin
                    neg_q <= dollars[DIV_BITS-1];
                    // A non-positive price cannot be divided; liquidate the position instead.
                    if (price_cur <= 16'sd0) begin
                        err      <= 1'b1;
                        target_q <= '0;
                    end
                end
                DIV: if (div_done) target_q <= sat16(quo_signed);
                EMIT: begin
                    if (fire) holdings[idx_q] <= target_q;
                    if ((fire || skip) && !last) idx_q <= idx_q + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_portfolio_rebalancer.sv
// Self-checking bench: vector table of runs, order scoreboard, backpressure and mid-divide reset.
module tb_portfolio_rebalancer;

    localparam int N = 3;
`ifdef REBAL_DEADBAND_EN
    localparam int DB_H1 = 0;
`else
    localparam int DB_H1 = 1;
`endif

    logic               clk = 1'b0;
    logic               rst_n, start, order_ready;
    logic [N-1:0][15:0] weights, prices, holdings;
    logic [15:0]        capital;
    logic               busy, order_valid, done, err;
    logic [1:0]         order_idx;
    logic [15:0]        order_qty;

    always #5 clk = ~clk;

    portfolio_rebalancer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .weights     (weights),
        .prices      (prices),
        .capital     (capital),
        .busy        (busy),
        .order_valid (order_valid),
        .order_ready (order_ready),
        .order_idx   (order_idx),
        .order_qty   (order_qty),
        .holdings    (holdings),
        .done        (done),
        .err         (err)
    );

    typedef struct {
        int cap;
        int w[N];
        int p[N];
        int q[N];
        int h[N];
        int err;
        int stall;
    } vec_t;

    typedef struct {
        int idx;
        int qty;
    } ord_t;

    vec_t vecs[$];
    ord_t exp_q[$];
    ord_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int cap, input int w0, input int w1, input int w2,
                       input int p0, input int p1, input int p2,
                       input int q0, input int q1, input int q2,
                       input int h0, input int h1, input int h2,
                       input int e, input int s);
        vec_t v;
        v.cap = cap;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
        v.p[0] = p0; v.p[1] = p1; v.p[2] = p2;
        v.q[0] = q0; v.q[1] = q1; v.q[2] = q2;
        v.h[0] = h0; v.h[1] = h1; v.h[2] = h2;
        v.err = e;
        v.stall = s;
        vecs.push_back(v);
    endtask

    function automatic bit emitted(input int q);
`ifdef REBAL_DEADBAND_EN
        return (q >= 2) || (q <= -2);
`else
        return (q == q);
`endif
    endfunction

    // Scoreboard: every handshake must match the oldest expected order.
    always @(negedge clk) begin
        if (rst_n && order_valid && order_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_order_idx", int'(order_idx), -1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("order_idx", int'(order_idx), mon_e.idx);
                chk("order_qty", int'($signed(order_qty)), mon_e.qty);
            end
        end
    end

    task automatic load(input vec_t v);
        capital = 16'(v.cap);
        for (int i = 0; i < N; i++) begin
            weights[i] = 16'(v.w[i]);
            prices[i]  = 16'(v.p[i]);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc, last_hs, first_idx, last_idx, stall_cnt, sv_idx, sv_qty, n_exp;
        bit   first_seen, stalling, fin;
        ord_t o;
        cyc = 0; last_hs = -100; first_idx = -1; last_idx = -1;
        stall_cnt = 0; sv_idx = 0; sv_qty = 0; n_exp = 0;
        first_seen = 1'b0; stalling = 1'b0; fin = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (emitted(v.q[i])) begin
                o.idx = i;
                o.qty = v.q[i];
                exp_q.push_back(o);
                n_exp++;
                if (first_idx < 0) first_idx = i;
                last_idx = i;
            end
        end
        @(posedge clk); #1;
        load(v);
        order_ready = (v.stall != 0 && n_exp > 0) ? 1'b0 : 1'b1;
        start = 1'b1;
        for (int it = 0; it < 400 && !fin; it++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (stalling) begin
                start = (stall_cnt == 3 || stall_cnt == 7);
                if (stall_cnt >= 10) begin
                    order_ready = 1'b1;
                    stalling    = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
            if (order_valid && !first_seen) begin
                first_seen = 1'b1;
                sv_idx = int'(order_idx);
                sv_qty = int'($signed(order_qty));
                if (first_idx == 0) chk("first_valid_latency", cyc, 26);
                stalling = !order_ready;
            end else if (stalling) begin
                chk("stall_valid", int'(order_valid), 1);
                chk("stall_idx", int'(order_idx), sv_idx);
                chk("stall_qty", int'($signed(order_qty)), sv_qty);
                stall_cnt++;
            end
            if (order_valid && order_ready) last_hs = cyc;
            if (done) begin
                fin = 1'b1;
                chk("busy_at_done", int'(busy), 0);
                if (last_idx == N - 1) chk("done_after_last_hs", cyc, last_hs + 1);
                for (int i = 0; i < N; i++) chk("holdings", int'($signed(holdings[i])), v.h[i]);
                chk("err", int'(err), v.err);
            end
        end
        if (!fin) chk("done_timeout_cycles", cyc, -1);
        @(posedge clk); #1;
        order_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("busy_after_run", int'(busy), 0);
        chk("valid_after_run", int'(order_valid), 0);
        chk("orders_outstanding", exp_q.size(), 0);
    endtask

    initial begin
        int n_valid;
        rst_n = 1'b0; start = 1'b0; order_ready = 1'b1;
        weights = '0; prices = '0; capital = '0;

        //   cap     weights               prices       exp qty            exp holdings      err stall
        add(10000,  8192, 4096, 0,      100, 50, 200,   50, 50, 0,         50, 50, 0,        0, 0);
        add(10000,  8192, 4096, 0,      100, 50, 200,   0, 0, 0,           50, 50, 0,        0, 1);
        add(10000, -8192, 4096, 0,      100, 50, 200,  -100, 0, 0,        -50, 50, 0,        0, 0);
        add(10000, -8192, 4096, 0,      100, 0, 200,    0, -50, 0,        -50, 0, 0,         1, 0);
        add(10000, -8192, 4096, 0,      100, 50, 200,   0, 50, 0,         -50, 50, 0,        1, 0);
        add(65535, 32767, 0, 0,         1, 1, 1,        32767, -50, 0,     32767, 0, 0,      1, 0);
        add(300,    0, 8192, 16384,     1, 150, 150,    0, 1, 2,           0, DB_H1, 2,      0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(order_valid), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_holdings", int'(holdings), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int k = 0; k < 6; k++) run_vec(vecs[k]);

        // Reset while the divider is mid-flight: everything clears and no order follows.
        @(posedge clk); #1;
        load(vecs[0]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_valid", int'(order_valid), 0);
        chk("midreset_err", int'(err), 0);
        for (int i = 0; i < N; i++) chk("midreset_holdings", int'($signed(holdings[i])), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_valid = 0;
        repeat (40) begin
            @(negedge clk);
            if (order_valid || busy) n_valid++;
        end
        chk("activity_after_midreset", n_valid, 0);

        run_vec(vecs[6]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
